// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// cla_pipe_adder : pipelined carry-lookahead adder/subtractor, WIDTH bits split
// into STAGES slices. Flags built only with `define CLA_PIPE_FLAGS_EN. Rev 1.0
// ============================================================================

module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NG    = SLICE / 4;
  localparam int LAST  = STAGES - 1;

  typedef struct packed {
    logic [SLICE-1:0] sum;
    logic             cout;
    logic             cmsb;
  } slice_t;

  // One pipeline stage: skewed operands, de-skewed partial sum, carry into
  // the next slice and the carry into the slice MSB (overflow source).
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             cmsb;
  } stage_t;

  function automatic slice_t cla_slice(input logic [SLICE-1:0] a,
                                       input logic [SLICE-1:0] b,
                                       input logic             cin);
    logic [SLICE-1:0] g, p, c;
    logic [NG-1:0]    gg, gp;
    logic [NG:0]      gc;
    logic             term;
    slice_t           r;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Group carries as flat sum-of-products over all lower groups.
    for (int j = 0; j <= NG; j++) begin
      gc[j] = cin;
      for (int m = 0; m < j; m++) gc[j] = gc[j] & gp[m];
      for (int m = 0; m < j; m++) begin
        term = gg[m];
        for (int n = m + 1; n < j; n++) term = term & gp[n];
        gc[j] = gc[j] | term;
      end
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    r.sum  = p ^ c;
    r.cout = gc[NG];
    r.cmsb = c[SLICE-1];
    return r;
  endfunction

  logic              adv;
  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  stage_t            w_cur;
  slice_t            w_res;

  assign adv     = ~v_q[LAST] | i_ready;
  assign o_ready = adv;
  assign o_valid = v_q[LAST];
  assign o_sum   = st_q[LAST].sum;

  always_comb begin
    w_cur = '0;
    w_res = '0;
    v_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = '0;
      if (k == 0) begin
        w_cur.a    = i_a;
        w_cur.b    = i_sub ? ~i_b : i_b;
        w_cur.sum  = '0;
        w_cur.cout = i_sub | i_cin;
        w_cur.cmsb = 1'b0;
        v_d[k]     = i_valid;
      end else begin
        w_cur  = st_q[(k > 0) ? k - 1 : 0];
        v_d[k] = v_q[(k > 0) ? k - 1 : 0];
      end
      w_res = cla_slice(w_cur.a[k*SLICE +: SLICE], w_cur.b[k*SLICE +: SLICE], w_cur.cout);
      st_d[k]                      = w_cur;
      st_d[k].sum[k*SLICE +: SLICE] = w_res.sum;
      st_d[k].cout                 = w_res.cout;
      st_d[k].cmsb                 = w_res.cmsb;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (adv) begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
    end
  end

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= st_d[LAST].cout ^ st_d[LAST].cmsb;
      zero_q <= ~|st_d[LAST].sum;
    end
  end

  assign o_carry = st_q[LAST].cout;
  assign o_ovf   = ovf_q;
  assign o_zero  = zero_q;
`else
  assign o_carry = 1'b0;
  assign o_ovf   = 1'b0;
  assign o_zero  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It splits a WIDTH-bit operation into STAGES equal slices, each built from 4-bit lookahead groups, and registers the inter-slice carry. Sustains one operation per cycle behind a valid/ready handshake with full backpressure. Sits between the operand-select logic and ALU result mux, for wide or high-frequency configurations where a single-cycle adder does not close timing.

## Interface
- WIDTH, 32: operand width; multiple of 4, at least 4.
- STAGES, 4: pipeline depth; must divide WIDTH/4; slice width SLICE = WIDTH/STAGES.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input operation valid.
- o_ready  out  1  adder can accept this cycle.
- i_a, i_b  in  WIDTH  operands.
- i_cin  in  1  carry-in (add mode only).
- i_sub  in  1  1 = a - b, 0 = a + b + cin.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_sum  out  WIDTH  result.
- o_carry  out  1  carry out of MSB (sub: 1 = no borrow).
- o_ovf  out  1  signed two's-complement overflow.
- o_zero  out  1  o_sum == 0.

## Operation
- Effective operands: b' = i_sub ? ~i_b : i_b; c0 = i_sub ? 1 : i_cin.
- Stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of a and b' with the carry registered from stage k-1 (c0 for stage 0).
- Within a slice: 4-bit groups compute g = a&b, p = a^b, group carries by full lookahead; group generate/propagate combine by lookahead across groups (no ripple between groups inside a slice).
- Higher slices of a and b' travel through skew registers; finished sum slices travel through de-skew registers, so the output word is aligned.
- Each stage holds a valid bit; bubbles advance like data.
- Global advance enable: adv = ~o_valid | i_ready; o_ready = adv. All stage registers load only when adv = 1.
- Input accepted when i_valid & o_ready; result transferred when o_valid & i_ready.
- o_ovf = carry into MSB XOR carry out of MSB; o_zero from the final assembled sum.

## Timing
- Latency: operation accepted on edge N appears on o_valid/o_sum after edge N+STAGES-1 (STAGES=1: registered output on next cycle).
- Throughput: 1 op/cycle while i_ready = 1.
- Stall: o_valid=1, i_ready=0 freezes every stage; o_sum and flags hold stable; o_ready=0; no ops lost or duplicated.
- Pipeline full and i_ready=1: accept and emit in same cycle.
- i_valid with o_ready=0: not accepted; source must hold.
- Reset (async assert, any time, mid-operation included): all valid bits 0, all data regs 0; o_valid=0, o_sum=0, o_carry=0, o_ovf=0, o_zero=0; o_ready=1 on first cycle after release. In-flight ops are discarded.
- Wrap: carry out of MSB is dropped from o_sum and reported only on o_carry.

## Configuration
- CLA_PIPE_FLAGS_EN defined: o_carry, o_ovf, o_zero computed and pipelined with o_sum as above.
- Not defined: flag logic and flag registers omitted; o_carry, o_ovf, o_zero tied to 0; o_sum, handshake and latency unchanged.

## Test plan
- WIDTH=32, STAGES=4, flags on: a=0xFFFFFFFF, b=0x00000001, add, cin=0 -> after 4 cycles o_sum=0x00000000, o_carry=1, o_zero=1, o_ovf=0.
- sub: a=5, b=7 -> o_sum=0xFFFFFFFE, o_carry=0, o_ovf=0, o_zero=0; a=7, b=5 -> o_sum=2, o_carry=1.
- add a=0x7FFFFFFF, b=1 -> o_sum=0x80000000, o_ovf=1; add a=0x0000FFFF, b=0, cin=1 -> o_sum=0x00010000 (carry crosses slice boundary).
- Stream 8 back-to-back random ops, i_ready low on cycles 3-5 -> all 8 results match model, in order, o_sum stable during stall, o_ready=0 while stalled with o_valid=1.
- Assert i_rst_n low with 3 ops in flight -> o_valid=0, all outputs 0 immediately; after release, new op returns correct result in 4 cycles, none of the old ops appear.
- Rebuild WIDTH=8, STAGES=1 and without CLA_PIPE_FLAGS_EN: 0xFF+0x01 -> o_sum=0x00 one cycle later, o_carry=o_ovf=o_zero=0.
